// File: rtl/desynk_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// desynk_top : double-blink heartbeat LED (pulse, gap, pulse, rest) from clk.
// Rev 1.0
// ---------------------------------------------------------------------------
module desynk_top #(
  parameter int TICK_DIV   = 2,
  parameter int ON_TICKS   = 1,
  parameter int GAP_TICKS  = 1,
  parameter int REST_TICKS = 2
) (
  input  logic clk,
  input  logic rst,
  output logic led1
);

  localparam int MAX_TICKS = (ON_TICKS > GAP_TICKS) ?
                             ((ON_TICKS > REST_TICKS) ? ON_TICKS : REST_TICKS) :
                             ((GAP_TICKS > REST_TICKS) ? GAP_TICKS : REST_TICKS);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W  = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  ON_LAST   = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0]  REST_LAST = PH_W'(REST_TICKS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE1 = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_PULSE2 = 3'd3;
  localparam logic [2:0] S_REST   = 3'd4;

  logic [1:0]       sync_q;
  logic             run;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  phase_last;
  logic             led1_q, led1_d;
  logic             tick;
  logic             phase_done;

  // Reset asserts asynchronously everywhere but is released to the FSM two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b00;
    else      sync_q <= {sync_q[0], 1'b1};
  end

  assign run        = sync_q[1];
  assign tick       = (state_q != S_IDLE) && (cnt_q == CNT_LAST);
  assign phase_done = tick && (phase_q == phase_last);

  always_comb begin
    case (state_q)
      S_PULSE1, S_PULSE2: phase_last = ON_LAST;
      S_GAP:              phase_last = GAP_LAST;
      default:            phase_last = REST_LAST;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q != S_IDLE && !tick) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    phase_d = phase_q;
    if (phase_done)  phase_d = '0;
    else if (tick)   phase_d = phase_q + PH_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      led1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led1_q  <= led1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run)        state_d = S_PULSE1;
      S_PULSE1: if (phase_done) state_d = S_GAP;
      S_GAP:    if (phase_done) state_d = S_PULSE2;
      S_PULSE2: if (phase_done) state_d = S_REST;
      S_REST:   if (phase_done) state_d = S_PULSE1;
      default:                  state_d = S_IDLE;
    endcase
  end

  // LED is decoded from the next state so it switches on the same edge as state_q.
  always_comb begin
    led1_d = (state_d == S_PULSE1) || (state_d == S_PULSE2);
  end

  assign led1 = led1_q;

endmodule
`default_nettype wire

// File: tb/tb_desynk_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_desynk_top : self-checking bench for desynk_top (three parameter sets).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_desynk_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led_a, led_b, led_c;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  desynk_top dut_a (.clk(clk), .rst(rst), .led1(led_a));

  desynk_top #(.TICK_DIV(1), .ON_TICKS(2), .GAP_TICKS(3), .REST_TICKS(4))
    dut_b (.clk(clk), .rst(rst), .led1(led_b));

  desynk_top #(.TICK_DIV(5), .ON_TICKS(1), .GAP_TICKS(1), .REST_TICKS(1))
    dut_c (.clk(clk), .rst(rst), .led1(led_c));

  // Expected LED level in cycle n (n=1 is the first cycle after release).
  function automatic logic exp_led(input int n, input int t, input int on,
                                   input int gap, input int rest);
    int per;
    int p;
    per = (2 * on + gap + rest) * t;
    p   = (n - 1) % per;
    return (p < on * t) || (p >= (on + gap) * t && p < (2 * on + gap) * t);
  endfunction

  task automatic hold_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Release between edges; after the synchroniser the next posedge is edge 1.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    int hold;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({led_a, led_b, led_c} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pre_edge: leds=%b required=000", {led_a, led_b, led_c});
    end
    hold = $urandom_range(2, 4);
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if ({led_a, led_b, led_c} !== 3'b000) begin
        failures++;
        $display("FAIL reset_hold: leds=%b required=000", {led_a, led_b, led_c});
      end
    end
  endtask

  task automatic test_basic();
    logic e;
    release_reset();
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      e = exp_led(n, 2, 1, 1, 2);
      checks++;
      if (led_a !== e) begin
        failures++;
        $display("FAIL basic cycle=%0d: led1=%b required=%b", n, led_a, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    int  stop;
    logic e;
    for (int k = 0; k < 4; k++) begin
      stop = (k == 0) ? 6 : int'($urandom_range(1, 25));
      hold_reset($urandom_range(1, 3));
      release_reset();
      for (int n = 1; n <= stop; n++) begin
        @(posedge clk);
        #1;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({led_a, led_b, led_c} !== 3'b000) begin
        failures++;
        $display("FAIL mid_reset_async stop=%0d: leds=%b required=000",
                 stop, {led_a, led_b, led_c});
      end
      @(negedge clk);
      release_reset();
      for (int n = 1; n <= 12; n++) begin
        @(posedge clk);
        #1;
        e = exp_led(n, 2, 1, 1, 2);
        checks++;
        if (led_a !== e) begin
          failures++;
          $display("FAIL mid_reset_replay stop=%0d cycle=%0d: led1=%b required=%b",
                   stop, n, led_a, e);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic eb, ec;
    hold_reset($urandom_range(1, 4));
    release_reset();
    for (int n = 1; n <= 44; n++) begin
      @(posedge clk);
      #1;
      eb = exp_led(n, 1, 2, 3, 4);
      ec = exp_led(n, 5, 1, 1, 1);
      checks++;
      if (led_b !== eb) begin
        failures++;
        $display("FAIL sweep_div1 cycle=%0d: led1=%b required=%b", n, led_b, eb);
      end
      checks++;
      if (led_c !== ec) begin
        failures++;
        $display("FAIL sweep_div5 cycle=%0d: led1=%b required=%b", n, led_c, ec);
      end
    end
  endtask

  task automatic test_long_run();
    logic e;
    logic prev;
    int   highs;
    int   last_rise;
    hold_reset($urandom_range(1, 4));
    release_reset();
    prev      = 1'b0;
    highs     = 0;
    last_rise = 0;
    for (int n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      e = exp_led(n, 2, 1, 1, 2);
      checks++;
      if (led_a !== e) begin
        failures++;
        $display("FAIL long_run cycle=%0d: led1=%b required=%b", n, led_a, e);
      end
      if (led_a === 1'b1) highs++;
      if (led_a === 1'b1 && prev === 1'b0 && (n % 10) == 1) begin
        if (last_rise != 0) begin
          checks++;
          if (n - last_rise != 10) begin
            failures++;
            $display("FAIL long_run_period cycle=%0d: spacing=%0d required=10",
                     n, n - last_rise);
          end
        end
        last_rise = n;
      end
      if (n % 10 == 0) begin
        checks++;
        if (highs != 4) begin
          failures++;
          $display("FAIL long_run_duty cycle=%0d: high_cycles=%0d required=4", n, highs);
        end
        highs = 0;
      end
      prev = led_a;
    end
    checks++;
    if (last_rise != 991) begin
      failures++;
      $display("FAIL long_run_last_rise: cycle=%0d required=991", last_rise);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_reset();
    test_sweep();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/desynk_top.md
Name: desynk_top

Overview:
- Top-level of the desynk board design: generates a fixed "double-blink" heartbeat pattern on a single LED from the system clock.
- Contains a free-running tick prescaler and a small phase state machine.
- The registered LED output proves clock, reset and the FPGA configuration are alive.

Parameters:
- TICK_DIV, 2, clock cycles per tick; legal range is 1 or more.
- ON_TICKS, 1, length of each LED-on pulse in ticks; legal range is 1 or more.
- GAP_TICKS, 1, LED-off gap between the two pulses in ticks; legal range is 1 or more.
- REST_TICKS, 2, LED-off rest after the second pulse in ticks; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- led1  output  1  heartbeat LED, driven directly from a flop; 1 = lit.

Behaviour:
- Single clock domain. rst is asynchronous and active-low.
  - While rst=0: state=IDLE, prescaler count=0, phase counter=0, led1=0, all forced immediately without waiting for a clock edge.
- Prescaler:
  - Count runs 0..TICK_DIV-1, then wraps to 0.
  - tick = (count==TICK_DIV-1), decoded from the registered count.
  - Count is held at 0 while in IDLE and starts incrementing on the edge that leaves IDLE.
  - With TICK_DIV=1, tick is constantly 1 outside IDLE.
- FSM states: IDLE, PULSE1, GAP, PULSE2, REST.
  - IDLE leaves to PULSE1 on the first rising edge with rst=1, unconditionally.
  - Each other state holds for its tick length: PULSE1 for ON_TICKS, GAP for GAP_TICKS, PULSE2 for ON_TICKS, REST for REST_TICKS.
  - A phase counter increments on each tick.
  - On the tick where phase counter == length-1, advance PULSE1→GAP→PULSE2→REST→PULSE1 and clear the phase counter.
  - IDLE is never re-entered except through reset.
- Every non-IDLE phase therefore lasts exactly length*TICK_DIV clock cycles.
  - Pattern period = (2*ON_TICKS+GAP_TICKS+REST_TICKS)*TICK_DIV cycles.
- Output:
  - led1 is a flop loaded with 1 when the next state is PULSE1 or PULSE2, 0 otherwise.
  - led1 changes on the same edge as the state register (zero extra latency, glitch-free).
- Widths:
  - Prescaler width is $clog2(TICK_DIV) with a minimum of 1 bit.
  - Phase counter is sized for max(ON_TICKS, GAP_TICKS, REST_TICKS).
  - No counter may overflow or wrap outside the rules above.
- Reset asserted mid-pattern (any state, any count): led1 drops to 0 asynchronously; after release the sequence restarts exactly as from power-up.
- Reset deasserted coincident with a clock edge is not required to be deterministic. Implementations synchronise rst deassertion with a 2-flop synchroniser (async assert, sync release); this adds 2 cycles before leaving IDLE.
  - All cycle numbers below count from the first edge at which the synchronised reset is inactive (edge 1).

Test Plan:
- Reset hold, defaults: rst=0 for 2 cycles -> led1=0 throughout, including before the first clock edge after rst falls.
- Basic pattern, defaults, edge 1 = first edge after synchronised release -> led1=1 on cycles 1-2, 0 on 3-4, 1 on 5-6, 0 on 7-10, 1 again from cycle 11. Period is 10 cycles; checked for 2 full periods.
- Reset mid-operation: assert rst during cycle 6 (PULSE2) for 1 cycle -> led1=0 immediately (asynchronous); after release the pattern replays from PULSE1 with the cycle numbering above.
- Parameter sweep TICK_DIV=1, ON_TICKS=2, GAP_TICKS=3, REST_TICKS=4 -> high 2, low 3, high 2, low 4 cycles; period 11 cycles.
- Parameter sweep TICK_DIV=5, all tick lengths=1 -> high 5, low 5, high 5, low 5; period 20 cycles; no extra cycle at any phase boundary.
- Long run: 1000 cycles with defaults -> every period is exactly 10 cycles with 4 high cycles; led1 never X after reset.
